// File: rtl/dmem_arb_pkg.sv
// Shared types for the vector data-memory arbiter: lane geometry, the vector
// word type and the sequencer state encoding.
package dmem_arb_pkg;

  localparam int LANES = 6;
  localparam int EW    = 8;

  typedef logic [LANES-1:0][EW-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_vect_arbiter_if.sv
// Bundle of both requester handshakes plus the single-port memory bus.
// The arbiter takes the slave side; the requesters and memory take the master side.
interface dmem_vect_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int AW = 32
);

  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  vec_t          wdata0, wdata1;
  logic          ack0, ack1;
  logic          err0, err1;
  vec_t          rdata0, rdata1;

  logic          mem_we;
  logic [AW-1:0] mem_a;
  vec_t          mem_wd;
  vec_t          mem_rd;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
    output ack0, ack1, err0, err1, rdata0, rdata1, mem_we, mem_a, mem_wd
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
    input  ack0, ack1, err0, err1, rdata0, rdata1, mem_we, mem_a, mem_wd
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, and under contention the
// port that was not granted last time wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  // NOTE: every output gets a value before the case so no path infers a latch.
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = 1'b0;
    case (req_i)
      2'b01:   gnt_idx_o = 1'b0;
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = ~last_gnt_i;
      default: gnt_idx_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_vect_arbiter.sv
// Serialises two requesters onto one vector data memory: IDLE arbitrates and
// latches the winner, ACCESS drives the memory, RESP acks the granted port.
module dmem_vect_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = 32
) (
  input logic               clk,
  input logic               rst,
  dmem_vect_arbiter_if.slave bus
);

  arb_state_t    state_q, state_d;
  logic          we_q;
  logic          gnt_q;
  logic          last_gnt_q;
  logic [AW-1:0] mem_a_q;
  vec_t          mem_wd_q;
  vec_t          rdata0_q, rdata1_q;

  logic          gnt_valid;
  logic          gnt_idx;
  logic          aligned;

  rr_arb2 u_rr_arb2 (
    .req_i       ({bus.req1, bus.req0}),
    .last_gnt_i  (last_gnt_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign aligned = (mem_a_q[1:0] == 2'b00);

  // Memory strobe, ack and err decode from registered state only, so they
  // vanish the moment reset forces state_q back to IDLE.
  always_comb begin
    state_d    = state_q;
    bus.mem_we = 1'b0;
    bus.ack0   = 1'b0;
    bus.ack1   = 1'b0;
    bus.err0   = 1'b0;
    bus.err1   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) state_d = ACCESS;
      end
      ACCESS: begin
        bus.mem_we = we_q & aligned;
        state_d    = RESP;
      end
      RESP: begin
        bus.ack0 = ~gnt_q;
        bus.ack1 = gnt_q;
        bus.err0 = ~gnt_q & ~aligned;
        bus.err1 = gnt_q & ~aligned;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      mem_a_q    <= '0;
      mem_wd_q   <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            gnt_q    <= gnt_idx;
            we_q     <= gnt_idx ? bus.we1    : bus.we0;
            mem_a_q  <= gnt_idx ? bus.addr1  : bus.addr0;
            mem_wd_q <= gnt_idx ? bus.wdata1 : bus.wdata0;
          end
        end
        ACCESS: begin
          if (!we_q && aligned) begin
            if (gnt_q) rdata1_q <= bus.mem_rd;
            else       rdata0_q <= bus.mem_rd;
          end
        end
        RESP: begin
          last_gnt_q <= gnt_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_a  = mem_a_q;
  assign bus.mem_wd = mem_wd_q;
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;

endmodule

// File: tb/tb_dmem_vect_arbiter.sv
// Randomised scoreboard bench for dmem_vect_arbiter: a transaction-level model
// predicts acks, errors, read data and memory writes; monitors compare them.
module tb_dmem_vect_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW    = 32;
  localparam int DEPTH = 64;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_fail;

  dmem_vect_arbiter_if #(.AW(AW)) bus ();

  dmem_vect_arbiter #(.AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory stand-in: synchronous write, combinational read, word addressed.
  vec_t phys [DEPTH];
  assign bus.mem_rd = phys[bus.mem_a[7:2]];
  always @(posedge clk) if (bus.mem_we) phys[bus.mem_a[7:2]] <= bus.mem_wd;

  // Transaction-level model state.
  typedef struct {
    bit   port;
    bit   err;
    vec_t rdata;
    int   ack_cyc;
  } resp_t;

  typedef struct {
    logic [AW-1:0] addr;
    vec_t          data;
    int            cyc;
  } wr_t;

  vec_t  ref_mem [DEPTH];
  vec_t  rd_model [2];
  bit    last_gnt_m;
  int    free_cyc;
  resp_t exp_q [$];
  wr_t   wq [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t rand_vec();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0];
  endfunction

  task automatic model_reset();
    rd_model[0] = '0;
    rd_model[1] = '0;
    last_gnt_m  = 1'b1;
    free_cyc    = cyc;
  endtask

  // One serialised access as the spec describes it: it starts once both the
  // request is up and the arbiter is idle, and acks two cycles after that.
  task automatic model_txn(input bit port, input bit we, input logic [AW-1:0] addr,
                           input vec_t wd, input int start_cyc);
    int ack;
    bit err;
    ack = ((start_cyc > free_cyc) ? start_cyc : free_cyc) + 2;
    err = (addr[1:0] != 2'b00);
    if (!err) begin
      if (we) begin
        ref_mem[addr[7:2]] = wd;
        wq.push_back('{addr, wd, ack - 1});
      end else begin
        rd_model[port] = ref_mem[addr[7:2]];
      end
    end
    exp_q.push_back('{port, err, rd_model[port], ack});
    last_gnt_m = port;
    free_cyc   = ack + 1;
  endtask

  // Called on a negedge; presents the requests and holds each until its ack.
  task automatic do_round(input bit [1:0] mask,
                          input bit w0, input logic [AW-1:0] a0, input vec_t d0,
                          input bit w1, input logic [AW-1:0] a1, input vec_t d1);
    int c;
    int budget;
    bit first;
    c = cyc;
    if (mask == 2'b11) begin
      first = ~last_gnt_m;
      if (first) begin
        model_txn(1'b1, w1, a1, d1, c);
        model_txn(1'b0, w0, a0, d0, c);
      end else begin
        model_txn(1'b0, w0, a0, d0, c);
        model_txn(1'b1, w1, a1, d1, c);
      end
    end else if (mask[0]) begin
      model_txn(1'b0, w0, a0, d0, c);
    end else begin
      model_txn(1'b1, w1, a1, d1, c);
    end
    bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    bus.req0 = mask[0];
    bus.req1 = mask[1];
    budget = 30;
    while ((bus.req0 || bus.req1) && budget > 0) begin
      @(negedge clk);
      if (bus.ack0) bus.req0 = 1'b0;
      if (bus.ack1) bus.req1 = 1'b0;
      budget--;
    end
    check("round_done", 64'({bus.req0, bus.req1}), 64'd0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  // Response monitor.
  always @(negedge clk) begin
    resp_t e;
    if (bus.ack0 && bus.ack1) begin
      n_cmp++; n_fail++;
      $display("FAIL dual_ack @cyc %0d: got ack0=1 ack1=1 expected at most one", cyc);
    end
    if ((bus.err0 && !bus.ack0) || (bus.err1 && !bus.ack1)) begin
      n_cmp++; n_fail++;
      $display("FAIL stray_err @cyc %0d: got err without ack expected none", cyc);
    end
    if (bus.ack0 || bus.ack1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_ack @cyc %0d: got ack0=%0b ack1=%0b expected none", cyc, bus.ack0, bus.ack1);
      end else begin
        e = exp_q.pop_front();
        check("ack_port",  64'(bus.ack1), 64'(e.port));
        check("ack_cycle", 64'(cyc), 64'(e.ack_cyc));
        check("ack_err",   64'(e.port ? bus.err1 : bus.err0), 64'(e.err));
        check("ack_rdata", 64'(e.port ? bus.rdata1 : bus.rdata0), 64'(e.rdata));
      end
    end
  end

  // Memory-write monitor.
  always @(negedge clk) begin
    wr_t w;
    if (bus.mem_we) begin
      if (wq.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_write @cyc %0d: got mem_we=1 a=%0h expected none", cyc, bus.mem_a);
      end else begin
        w = wq.pop_front();
        check("wr_cycle", 64'(cyc), 64'(w.cyc));
        check("wr_addr",  64'(bus.mem_a), 64'(w.addr));
        check("wr_data",  64'(bus.mem_wd), 64'(w.data));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          old;
    bit [1:0]      mask;
    logic [AW-1:0] a0, a1;
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.we0  = 1'b0; bus.we1  = 1'b0;
    bus.addr0 = '0;  bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      phys[i]    = rand_vec();
      ref_mem[i] = phys[i];
    end

    // Reset with random inputs: all outputs held at zero.
    repeat (4) begin
      bus.req0 = 1'($urandom()); bus.req1 = 1'($urandom());
      bus.we0  = 1'($urandom()); bus.we1  = 1'($urandom());
      bus.addr0 = $urandom(); bus.addr1 = $urandom();
      bus.wdata0 = rand_vec(); bus.wdata1 = rand_vec();
      @(negedge clk);
      check("rst_ctl",    64'({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_we}), 64'd0);
      check("rst_rdata0", 64'(bus.rdata0), 64'd0);
      check("rst_rdata1", 64'(bus.rdata1), 64'd0);
      check("rst_mem_a",  64'(bus.mem_a), 64'd0);
      check("rst_mem_wd", 64'(bus.mem_wd), 64'd0);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (10) begin
      @(negedge clk);
      check("idle_quiet", 64'({bus.mem_we, bus.ack0, bus.ack1}), 64'd0);
    end

    // Port 1 writes a known word, port 0 reads it back.
    do_round(2'b10, 1'b0, '0, '0, 1'b1, 32'h0, 48'h00_11_22_33_44_55);
    do_round(2'b01, 1'b0, 32'h0, '0, 1'b0, '0, '0);

    // Port 1 back-to-back reads with port 0 idle.
    do_round(2'b10, 1'b0, '0, '0, 1'b0, 32'h0, '0);
    do_round(2'b10, 1'b0, '0, '0, 1'b0, 32'h4, '0);
    do_round(2'b10, 1'b0, '0, '0, 1'b0, 32'h8, '0);

    // Contention: both ports held, writes then reads of 0x4 / 0x8.
    do_round(2'b11, 1'b1, 32'h4, rand_vec(), 1'b1, 32'h8, rand_vec());
    do_round(2'b11, 1'b0, 32'h4, '0, 1'b0, 32'h8, '0);

    // Misaligned write is rejected and leaves 0x4 intact.
    repeat (2) @(negedge clk);
    do_round(2'b01, 1'b1, 32'h6, rand_vec(), 1'b0, '0, '0);
    do_round(2'b01, 1'b0, 32'h4, '0, 1'b0, '0, '0);

    // Reset during the ACCESS cycle of a write to 0x10.
    repeat (2) @(negedge clk);
    old = ref_mem[4];
    bus.we0 = 1'b1; bus.addr0 = 32'h10; bus.wdata0 = ~old;
    bus.req0 = 1'b1;
    @(posedge clk);
    #2;
    check("midrst_we_on", 64'(bus.mem_we), 64'd1);
    rst = 1'b0;
    #1;
    check("midrst_we_drop", 64'(bus.mem_we), 64'd0);
    bus.req0 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("midrst_quiet", 64'({bus.ack0, bus.ack1, bus.mem_we}), 64'd0);
    end
    rst = 1'b1;
    model_reset();
    do_round(2'b01, 1'b0, 32'h10, '0, 1'b0, '0, '0);
    check("midrst_old_data", 64'(bus.rdata0), 64'(old));

    // Randomised traffic.
    for (int r = 0; r < 60; r++) begin
      mask = 2'($urandom_range(1, 3));
      a0 = 32'($urandom_range(0, 15) * 4);
      a1 = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 5) == 0) a0 = a0 + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) a1 = a1 + 32'($urandom_range(1, 3));
      do_round(mask, 1'($urandom()), a0, rand_vec(), 1'($urandom()), a1, rand_vec());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("resp_drained",  64'(exp_q.size()), 64'd0);
    check("write_drained", 64'(wq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
